pwm_driver: RTL

Final stage of the fuzzy speed/frequency controller, directly downstream of defuzzification. Consumes the crisp 8-bit duty command (percent of period) and generates the physical PWM waveform. Runs a prescaled period counter and latches the duty only at period boundaries, so every period is glitch-free. Applies a per-period slew limit so abrupt changes in the fuzzy output never step the load.

---
 rtl/pwm_driver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pwm_driver.sv
// Prescaled PWM generator with period-boundary duty latching and per-period slew limiting.
// Optional PWM_COMPLEMENT_EN adds a dead-time protected complementary output pwm_out_n.
module pwm_driver #(
  parameter int unsigned DUTY_MAX  = 100,
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned SLEW_STEP = 10,
  parameter int unsigned DEAD_TIME = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] duty,
  output logic       pwm_out,
  output logic       period_start,
  output logic [7:0] active_duty
`ifdef PWM_COMPLEMENT_EN
  ,
  output logic       pwm_out_n
`endif
);

  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [8:0]  MAX9  = 9'(DUTY_MAX);
  localparam logic [8:0]  SLEW9 = 9'(SLEW_STEP);

  if (PRESCALE == 0 || DUTY_MAX == 0 || DUTY_MAX > 255 || SLEW_STEP > 255 || DEAD_TIME > 255)
  begin : g_param_chk
    $error("pwm_driver: parameter out of range");
  end

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic             start_q, start_d;
  logic             pwm_q, pwm_d;

  logic [8:0] target, cur, duty_new, eff;
  logic       psc_last, cnt_last, start_c, raw_c;

`ifdef PWM_COMPLEMENT_EN
  localparam int unsigned      DT_W = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
  localparam logic [DT_W-1:0]  DT   = DT_W'(DEAD_TIME);

  logic [DT_W-1:0] on_q, on_d, off_q, off_d;
  logic            pwm_n_q, pwm_n_d;
  logic            raw_n_c;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q   <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      start_q <= 1'b0;
      pwm_q   <= 1'b0;
`ifdef PWM_COMPLEMENT_EN
      on_q    <= '0;
      off_q   <= '0;
      pwm_n_q <= 1'b0;
`endif
    end else begin
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      start_q <= start_d;
      pwm_q   <= pwm_d;
`ifdef PWM_COMPLEMENT_EN
      on_q    <= on_d;
      off_q   <= off_d;
      pwm_n_q <= pwm_n_d;
`endif
    end
  end

  // Slew-limited move of the active duty toward the clamped command (9-bit to avoid wrap)
  always_comb begin
    target   = (9'(duty) > MAX9) ? MAX9 : 9'(duty);
    cur      = 9'(duty_q);
    duty_new = target;
    if (SLEW_STEP != 0) begin
      if ((target > cur) && ((target - cur) > SLEW9)) begin
        duty_new = cur + SLEW9;
      end else if ((cur > target) && ((cur - target) > SLEW9)) begin
        duty_new = cur - SLEW9;
      end
    end
  end

  // Next-state logic
  always_comb begin
    psc_last = (psc_q == PSC_W'(PRESCALE - 1));
    cnt_last = (cnt_q == 8'(DUTY_MAX - 1));
    start_c  = enable && (psc_q == '0) && (cnt_q == '0);
    eff      = start_c ? duty_new : cur;
    raw_c    = enable && (9'(cnt_q) < eff);

    psc_d   = '0;
    cnt_d   = '0;
    duty_d  = '0;
    start_d = 1'b0;
    if (enable) begin
      psc_d   = psc_last ? '0 : psc_q + PSC_W'(1);
      cnt_d   = cnt_q;
      if (psc_last) cnt_d = cnt_last ? 8'd0 : cnt_q + 8'd1;
      duty_d  = start_c ? duty_new[7:0] : duty_q;
      start_d = start_c;
    end

`ifdef PWM_COMPLEMENT_EN
    // A side only turns on once its raw request has already held for DEAD_TIME clks
    raw_n_c = enable && (9'(cnt_q) >= eff);
    on_d    = raw_c   ? ((on_q  == DT) ? on_q  : on_q  + DT_W'(1)) : '0;
    off_d   = raw_n_c ? ((off_q == DT) ? off_q : off_q + DT_W'(1)) : '0;
    pwm_d   = raw_c   && (on_q  >= DT);
    pwm_n_d = raw_n_c && (off_q >= DT);
`else
    pwm_d   = raw_c;
`endif
  end

  // Outputs
  always_comb begin
    pwm_out      = pwm_q;
    period_start = start_q;
    active_duty  = duty_q;
`ifdef PWM_COMPLEMENT_EN
    pwm_out_n    = pwm_n_q;
`endif
  end

endmodule
